// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider controller.
package div_ctrl_pkg;

  // Controller states; the encoding is also exported on the debug port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Default operand/result width.
  localparam int WIDTH_DEF = 32;

  // Most negative value at the default width.
  localparam logic [WIDTH_DEF-1:0] INT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

  // Settle counter width; holds SETTLE_CYCLES-1 for SETTLE_CYCLES in 1..15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/div_special_detect.sv
// Classifies an operand pair as divide-by-zero, INT_MIN/-1 overflow, or normal.
// Purely combinational; the two flags are never both set.
module div_special_detect
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             is_zero,
  output logic             is_ovf
);

  localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

  // Zero divisor wins; overflow is only INT_MIN divided by -1.
  always_comb begin
    is_zero = (divisor == '0);
    is_ovf  = (dividend == MIN_W) && (divisor == '1);
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle controller around a combinational signed divider core.
// Operands are latched on start and held on the core inputs for SETTLE_CYCLES
// cycles, then quotient/remainder are captured into LO/HI.
// Divide-by-zero and INT_MIN/-1 are resolved here without using the core.
// Optional feature macro: DIV_ZERO_TRAP_EN (zero divisor raises div_trap and
// leaves HI/LO untouched instead of writing all-ones/dividend).
//
// Handshake: start is a request sampled only in IDLE or DONE; there is no
// ready. busy is high while the core is still settling, done pulses for one
// cycle when results are valid in hi_out/lo_out. start while settling is dropped.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             div_trap,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output state_t           dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] hi_nx, lo_nx, opa_nx, opb_nx;
  logic             dbz_nx;
  logic             is_zero, is_ovf;
`ifdef DIV_ZERO_TRAP_EN
  logic             trap_q, trap_nx;
`endif

  div_special_detect #(.WIDTH(WIDTH)) u_detect (
    .dividend (dividend),
    .divisor  (divisor),
    .is_zero  (is_zero),
    .is_ovf   (is_ovf)
  );

  // State, counter, operand and result registers.
  always_ff @(posedge clock) begin
    if (!clr_n) begin
      state        <= IDLE;
      cnt          <= '0;
      hi_out       <= '0;
      lo_out       <= '0;
      div_by_zero  <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
`ifdef DIV_ZERO_TRAP_EN
      trap_q       <= 1'b0;
`endif
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      hi_out       <= hi_nx;
      lo_out       <= lo_nx;
      div_by_zero  <= dbz_nx;
      div_dividend <= opa_nx;
      div_divisor  <= opb_nx;
`ifdef DIV_ZERO_TRAP_EN
      trap_q       <= trap_nx;
`endif
    end
  end

  // Next-state and register updates; everything holds unless a branch says otherwise.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hi_nx    = hi_out;
    lo_nx    = lo_out;
    dbz_nx   = div_by_zero;
    opa_nx   = div_dividend;
    opb_nx   = div_divisor;
`ifdef DIV_ZERO_TRAP_EN
    trap_nx  = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (start) begin
          opa_nx = dividend;
          opb_nx = divisor;
          if (is_zero) begin
            state_nx = DONE;
            dbz_nx   = 1'b1;
`ifdef DIV_ZERO_TRAP_EN
            trap_nx  = 1'b1;
`else
            lo_nx    = '1;
            hi_nx    = dividend;
`endif
          end else if (is_ovf) begin
            state_nx = DONE;
            lo_nx    = MIN_W;
            hi_nx    = '0;
            dbz_nx   = 1'b0;
          end else begin
            state_nx = SETTLE;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nx = DONE;
          lo_nx    = div_quotient;
          hi_nx    = div_remainder;
          dbz_nx   = 1'b0;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // busy covers the settle window up to, not including, the capture cycle,
  // so a single-cycle settle never raises it.
  assign busy      = (state == SETTLE) && (cnt != '0);
  assign done      = (state == DONE);
  assign dbg_state = state;

`ifdef DIV_ZERO_TRAP_EN
  assign div_trap = trap_q;
`else
  assign div_trap = 1'b0;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: table of directed vectors, hand-written corner
// sequences (back-to-back, start while settling, reset abort) and random
// operations checked against an arithmetic reference model.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  logic         clock, clr_n, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero, div_trap;
  logic [W-1:0] hi_out, lo_out, div_dividend, div_divisor;
  logic [W-1:0] div_quotient, div_remainder;
  state_t       dbg_state;

  div_ctrl #(.WIDTH(W), .SETTLE_CYCLES(N)) dut (
    .clock         (clock),
    .clr_n         (clr_n),
    .start         (start),
    .dividend      (dividend),
    .divisor       (divisor),
    .busy          (busy),
    .done          (done),
    .div_by_zero   (div_by_zero),
    .div_trap      (div_trap),
    .hi_out        (hi_out),
    .lo_out        (lo_out),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational core stand-in; special operand pairs give a poison value
  // so that any use of the core for them is visible.
  always_comb begin
    if (div_divisor == '0 || (div_dividend == INT_MIN && div_divisor == '1)) begin
      div_quotient  = 32'hDEAD_BEEF;
      div_remainder = 32'hDEAD_BEEF;
    end else begin
      div_quotient  = $signed(div_dividend) / $signed(div_divisor);
      div_remainder = $signed(div_dividend) % $signed(div_divisor);
    end
  end

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_hi, m_lo;
  logic         m_dbz;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
    logic         trap;
    int           lat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model from the divide rules, using 64-bit arithmetic.
  // lat = clock edges after the start-sampling edge until done is visible.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] lo, output logic [W-1:0] hi,
                       output logic dbz, output logic trap, output int lat);
    longint sa, sb;
    lat  = 0;
    trap = 1'b0;
    lo   = m_lo;
    hi   = m_hi;
    if (b == '0) begin
      dbz = 1'b1;
`ifdef DIV_ZERO_TRAP_EN
      trap = 1'b1;
`else
      lo = '1;
      hi = a;
`endif
    end else if (a == INT_MIN && b == '1) begin
      lo  = INT_MIN;
      hi  = '0;
      dbz = 1'b0;
    end else begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lo  = W'(sa / sb);
      hi  = W'(sa % sb);
      dbz = 1'b0;
      lat = N;
    end
    m_lo  = lo;
    m_hi  = hi;
    m_dbz = dbz;
  endtask

  // Driver: issue one op, wait (bounded) for done, compare against expectations.
  // With b2b set it returns inside the DONE cycle so the next op starts back-to-back.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e_lo, input logic [W-1:0] e_hi,
                        input logic e_dbz, input logic e_trap, input int e_lat,
                        input bit b2b, input string tag);
    int lat, busy_n;
    bit stable;
    exp_q.push_back(e_lo);
    exp_q.push_back(e_hi);
    @(negedge clock);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clock); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = 0; busy_n = 0; stable = 1'b1;
    while (!done && lat < 40) begin
      busy_n += int'(busy);
      if (div_dividend !== a || div_divisor !== b) stable = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(e_lat));
    chk({tag, " busy cycles"}, 64'(busy_n), 64'((e_lat > 0) ? e_lat - 1 : 0));
    chk({tag, " operands held"}, 64'(stable), 64'd1);
    chk({tag, " lo"}, 64'(lo_out), 64'(exp_q.pop_front()));
    chk({tag, " hi"}, 64'(hi_out), 64'(exp_q.pop_front()));
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(e_dbz));
    chk({tag, " div_trap"}, 64'(div_trap), 64'(e_trap));
    if (!b2b) begin
      @(posedge clock); #1;
      chk({tag, " done drop"}, 64'(done), 64'd0);
      chk({tag, " trap drop"}, 64'(div_trap), 64'd0);
      chk({tag, " idle"}, 64'(dbg_state), 64'(IDLE));
    end
  endtask

  task automatic model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit b2b, input string tag);
    logic [W-1:0] lo, hi;
    logic         dbz, trap;
    int           lat;
    model(a, b, lo, hi, dbz, trap, lat);
    run_op(a, b, lo, hi, dbz, trap, lat, b2b, tag);
  endtask

  initial begin
    logic [W-1:0] lo, hi;
    logic         dbz, trap;
    int           lat;
    bit           seen;

    clr_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset state", 64'(dbg_state), 64'(IDLE));
    chk("reset busy/done/dbz/trap", 64'({busy, done, div_by_zero, div_trap}), 64'd0);
    chk("reset hi", 64'(hi_out), 64'd0);
    chk("reset lo", 64'(lo_out), 64'd0);
    chk("reset operands", {div_dividend, div_divisor}, 64'd0);
    clr_n = 1'b1;

    // Directed vectors: {a, b, lo, hi, dbz, trap, latency}
    tbl[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, N};
`ifdef DIV_ZERO_TRAP_EN
    tbl[1] = '{32'd55, 32'd0, 32'd14, 32'd2, 1'b1, 1'b1, 0};
`else
    tbl[1] = '{32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1, 1'b0, 0};
`endif
    tbl[2] = '{32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, N};
    tbl[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 0};
    tbl[4] = '{32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, N};
    tbl[5] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, N};
`ifdef DIV_ZERO_TRAP_EN
    tbl[6] = '{32'd0, 32'd0, 32'd3, 32'hFFFF_FFFF, 1'b1, 1'b1, 0};
`else
    tbl[6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 0};
`endif
    tbl[7] = '{32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, N};
    tbl[8] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32'd0, 1'b0, 1'b0, N};

    for (int i = 0; i < 9; i++) begin
      model(tbl[i].a, tbl[i].b, lo, hi, dbz, trap, lat);
      run_op(tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, tbl[i].dbz, tbl[i].trap,
             tbl[i].lat, 1'b0, $sformatf("vec%0d", i));
    end

    // Back-to-back: start sampled in DONE, including special then normal.
    model_op(32'd100, 32'd7, 1'b1, "b2b first");
    model_op(32'd9, 32'd3, 1'b1, "b2b second");
    model_op(32'd13, 32'd0, 1'b1, "b2b zero");
    model_op(32'd50, 32'd8, 1'b0, "b2b last");

    // Start while settling is ignored; 100/7 must be the captured result.
    model(32'd100, 32'd7, lo, hi, dbz, trap, lat);
    @(negedge clock);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock); #1;
    dividend = 32'd9; divisor = 32'd3;
    @(posedge clock); #1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 2;
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("ignore latency", 64'(lat), 64'(N));
    chk("ignore lo", 64'(lo_out), 64'd14);
    chk("ignore hi", 64'(hi_out), 64'd2);
    chk("ignore operand", 64'(div_dividend), 64'd100);
    @(posedge clock); #1;
    chk("ignore done drop", 64'(done), 64'd0);

    // Reset two cycles into a normal op aborts it.
    @(negedge clock);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    clr_n = 1'b0;
    @(posedge clock); #1;
    chk("abort state", 64'(dbg_state), 64'(IDLE));
    chk("abort busy/done/dbz/trap", 64'({busy, done, div_by_zero, div_trap}), 64'd0);
    chk("abort hi/lo", {hi_out, lo_out}, 64'd0);
    chk("abort operands", {div_dividend, div_divisor}, 64'd0);
    clr_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clock); #1;
      seen |= done;
    end
    chk("abort no done", 64'(seen), 64'd0);
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;

    // Random operations against the model, biased toward the special cases.
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] a, b;
      int sel;
      sel = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      case (sel)
        0: b = '0;
        1: begin a = INT_MIN; b = '1; end
        2: b = W'($urandom_range(1, 9));
        3: b = '0 - W'($urandom_range(1, 9));
        4: a = W'($urandom_range(0, 200));
        default: ;
      endcase
      model_op(a, b, bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end
    @(posedge clock); #1;
    chk("final state", 64'(dbg_state), 64'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the run is bounded well below this.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
